// File: rtl/proj_to_affine.sv
// proj_to_affine: converts one projective point (X2, Y2, Z2) over GF(P) to affine
// coordinates x = X2 / Z2, y = Y2 / Z2 (mod P). The inverse of Z2 is computed as
// Z2^(P-2) (Fermat) with one square-and-multiply step per cycle, MSB first.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input handshake; X2, Y2, Z2 captured on accept
//   out_valid / out_ready output handshake; x_aff, y_aff, is_inf valid in DONE
//   is_inf                set when Z2 mod P == 0 (x_aff = y_aff = 0 then)
//
// Latency from accept to out_valid is a fixed EW+1 cycles.
module proj_to_affine #(
  parameter int unsigned W = 4,
  parameter int unsigned P = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] X2,
  input  logic [W-1:0] Y2,
  input  logic [W-1:0] Z2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] x_aff,
  output logic [W-1:0] y_aff,
  output logic         is_inf
);

  localparam int unsigned EW = $clog2(P);
  localparam int unsigned IW = (EW > 1) ? $clog2(EW) : 1;
  localparam logic [EW-1:0]  Exp = EW'(P - 2);
  localparam logic [2*W-1:0] PW  = (2*W)'(P);
  localparam logic [W-1:0]   One = W'(1);

  typedef enum logic [1:0] {StIdle, StExp, StMul, StDone} state_e;

  // Reduce a double-width value into the field.
  function automatic logic [W-1:0] mod_red(input logic [2*W-1:0] a);
    logic [2*W-1:0] r;
    r = a % PW;
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return mod_red(prod);
  endfunction

  state_e         state_q, state_d;
  logic [W-1:0]   xr_q, xr_d, yr_q, yr_d, zr_q, zr_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           inf_r_q, inf_r_d;
  logic [W-1:0]   x_aff_q, x_aff_d, y_aff_q, y_aff_d;
  logic           is_inf_q, is_inf_d;

  logic [W-1:0]   acc_sq, acc_step, z_red;

  // One exponent step: square, then multiply by Z only where the exponent bit is set.
  assign acc_sq   = mod_mul(acc_q, acc_q);
  assign acc_step = mod_mul(acc_sq, Exp[idx_q] ? zr_q : One);
  assign z_red    = mod_red({{W{1'b0}}, Z2});

  always_comb begin
    state_d  = state_q;
    xr_d     = xr_q;
    yr_d     = yr_q;
    zr_d     = zr_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    inf_r_d  = inf_r_q;
    x_aff_d  = x_aff_q;
    y_aff_d  = y_aff_q;
    is_inf_d = is_inf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          xr_d    = mod_red({{W{1'b0}}, X2});
          yr_d    = mod_red({{W{1'b0}}, Y2});
          zr_d    = z_red;
          acc_d   = One;
          idx_d   = IW'(EW - 1);
          inf_r_d = (z_red == '0);
          state_d = StExp;
        end
      end
      StExp: begin
        acc_d = acc_step;
        if (idx_q == '0) begin
          state_d = StMul;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      StMul: begin
        x_aff_d  = mod_mul(xr_q, acc_q);
        y_aff_d  = mod_mul(yr_q, acc_q);
        is_inf_d = inf_r_q;
        state_d  = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      xr_q     <= '0;
      yr_q     <= '0;
      zr_q     <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      inf_r_q  <= 1'b0;
      x_aff_q  <= '0;
      y_aff_q  <= '0;
      is_inf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      xr_q     <= xr_d;
      yr_q     <= yr_d;
      zr_q     <= zr_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      inf_r_q  <= inf_r_d;
      x_aff_q  <= x_aff_d;
      y_aff_q  <= y_aff_d;
      is_inf_q <= is_inf_d;
    end
  end

  // Gate with rst_n so in_ready is low for the whole reset window.
  assign in_ready  = (state_q == StIdle) && rst_n;
  assign out_valid = (state_q == StDone);
  assign x_aff     = x_aff_q;
  assign y_aff     = y_aff_q;
  assign is_inf    = is_inf_q;

endmodule

// File: tb/tb_proj_to_affine.sv
module tb_proj_to_affine;
  localparam int W  = 4;
  localparam int P  = 11;
  localparam int EW = $clog2(P);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] X2 = '0, Y2 = '0, Z2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] x_aff, y_aff;
  logic         is_inf;

  proj_to_affine #(.W(W), .P(P)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .X2       (X2),
    .Y2       (Y2),
    .Z2       (Z2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x_aff    (x_aff),
    .y_aff    (y_aff),
    .is_inf   (is_inf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int x;
    int y;
    int inf;
    int t;
  } exp_t;

  exp_t sb[$];

  // Reference: affine conversion by brute-force search for the field inverse.
  function automatic exp_t model(input int x, input int y, input int z, input int t);
    exp_t m;
    int zr, inv;
    zr = z % P;
    inv = 0;
    for (int k = 1; k < P; k++) if ((zr * k) % P == 1) inv = k;
    m.x   = ((x % P) * inv) % P;
    m.y   = ((y % P) * inv) % P;
    m.inf = (zr == 0) ? 1 : 0;
    m.t   = t;
    return m;
  endfunction

  // out_ready driver: directed value or random backpressure.
  bit bp_mode = 1'b0;
  bit or_dir  = 1'b0;
  always @(posedge clk) begin
    #1;
    out_ready = bp_mode ? ($urandom_range(0, 3) != 0) : or_dir;
  end

  // Monitor: samples at negedge, compares against scoreboard front.
  bit prev_v = 1'b0;
  bit chk_rdy = 1'b0;
  always @(negedge clk) begin
    if (chk_rdy) begin
      check("in_ready_after_handshake", int'(in_ready), 1);
      chk_rdy = 1'b0;
    end
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_output", int'(out_valid), 0);
      end else begin
        exp_t e;
        e = sb[0];
        if (!prev_v) check("latency", cyc, e.t + EW + 1);
        check("x_aff", int'(x_aff), e.x);
        check("y_aff", int'(y_aff), e.y);
        check("is_inf", int'(is_inf), e.inf);
        check("in_ready_in_done", int'(in_ready), 0);
        if (out_ready) begin
          void'(sb.pop_front());
          chk_rdy = 1'b1;
        end
      end
    end
    prev_v = out_valid;
  end

  task automatic send(input int x, input int y, input int z);
    int n;
    @(posedge clk);
    #1;
    X2 = W'(x);
    Y2 = W'(y);
    Z2 = W'(z);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", int'(in_ready), 1);
    else sb.push_back(model(x, y, z, cyc + 1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    X2 = W'($urandom);
    Y2 = W'($urandom);
    Z2 = W'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, int'(out_valid), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset values
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_x_aff", int'(x_aff), 0);
    check("rst_y_aff", int'(y_aff), 0);
    check("rst_is_inf", int'(is_inf), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);

    // Directed points with the consumer always ready
    or_dir = 1'b1;
    send(2, 1, 1);
    wait_idle();
    send(7, 6, 5);
    send(1, 1, 3);
    send(3, 4, 0);
    send(13, 14, 12);
    send(0, 9, 11);
    wait_idle();

    // Backpressure: outputs hold, in_valid pulses in DONE are ignored
    or_dir = 1'b0;
    send(7, 6, 5);
    wait_valid("bp_reach_done");
    for (int i = 0; i < 4; i++) begin
      in_valid = (i % 2 == 0);
      X2 = 4'd2;
      Y2 = 4'd1;
      Z2 = 4'd1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    or_dir = 1'b1;
    wait_idle();

    // Reset during EXP aborts the transaction
    send(7, 6, 5);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_exp_out_valid", int'(out_valid), 0);
    check("abort_exp_in_ready", int'(in_ready), 0);
    check("abort_exp_x_aff", int'(x_aff), 0);
    check("abort_exp_y_aff", int'(y_aff), 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("abort_exp_idle", int'(in_ready), 1);
    send(2, 1, 1);
    wait_idle();

    // Reset while holding a result in DONE drops out_valid asynchronously
    or_dir = 1'b0;
    send(3, 5, 7);
    wait_valid("rst_done_reach");
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_done_out_valid", int'(out_valid), 0);
    check("abort_done_x_aff", int'(x_aff), 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    or_dir = 1'b1;
    send(1, 1, 3);
    wait_idle();

    // Randomized traffic with random consumer backpressure
    bp_mode = 1'b1;
    repeat (150) send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    wait_idle();
    bp_mode = 1'b0;

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
